// File: rtl/pes_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encoding and default width.
package pes_arith_pkg;

    localparam int unsigned PES_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } pes_state_t;

endpackage

// File: rtl/pes_full_subtractor.sv
// One-bit full subtractor: a - b - bin, producing a difference bit and a borrow out.
module pes_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/pes_serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per cycle, valid/ready on both sides.
module pes_serial_subtractor
    import pes_arith_pkg::*;
#(
    parameter int unsigned WIDTH = PES_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    pes_state_t       r_state;
    pes_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_accept;
    logic             w_calc;
    logic             w_last;

    pes_full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .diff (w_d),
        .bout (w_bo)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_next = CALC;
            end
            CALC: begin
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && i_valid;
    assign w_calc   = (r_state == CALC);
    assign w_last   = w_calc && (r_cnt == LAST);

    // Result goes to separate output registers only on the final bit, so o_diff
    // never shows a partially shifted value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= i_a;
                r_b      <= i_b;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
            end else if (w_calc) begin
                r_a      <= r_a >> 1;
                r_b      <= r_b >> 1;
                r_sh     <= {w_d, r_sh[WIDTH-1:1]};
                r_borrow <= w_bo;
                if (!w_last) r_cnt <= r_cnt + CW'(1);
            end
            if (w_last) begin
                r_diff <= {w_d, r_sh[WIDTH-1:1]};
                r_bout <= w_bo;
            end
        end
    end

    assign o_diff   = r_diff;
    assign o_borrow = r_bout;

endmodule

// File: tb/tb_pes_serial_subtractor.sv
// Scoreboard bench for pes_serial_subtractor (WIDTH=8): driver pushes expectations, monitor checks results.
module tb_pes_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;

    int   total;
    int   bad;
    int   cyc;
    exp_t q[$];
    bit   seen;
    bit   hs_prev;
    int   last_acc;

    pes_serial_subtractor #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare against scoreboard head every cycle o_valid is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hs_prev) begin
                check("ready_after_hs", int'(o_ready), 1);
                check("valid_after_hs", int'(o_valid), 0);
                hs_prev = 1'b0;
            end
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc - q[0].acc, int'(W) + 1);
                        seen = 1'b1;
                    end
                    check("diff", int'(o_diff), int'(q[0].d));
                    check("borrow", int'(o_borrow), int'(q[0].b));
                    if (i_ready) begin
                        void'(q.pop_front());
                        seen    = 1'b0;
                        hs_prev = 1'b1;
                    end
                end
            end
        end else begin
            seen    = 1'b0;
            hs_prev = 1'b0;
        end
    end

    // Drive one operand pair; optionally keep i_valid high with other operands afterwards.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input bit push,
                        input bit keep, input logic [W-1:0] na, input logic [W-1:0] nb,
                        output int acc);
        bit   done;
        exp_t e;
        done = 1'b0;
        acc  = -1;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        for (int unsigned k = 0; k < 200 && !done; k++) begin
            if (o_ready) begin
                acc = cyc;
                if (push) begin
                    e.d   = ed;
                    e.b   = eb;
                    e.acc = cyc;
                    q.push_back(e);
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 0, 1);
        if (keep) begin
            i_a = na;
            i_b = nb;
        end else begin
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         acc;
        int         vcount;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        seen     = 1'b0;
        hs_prev  = 1'b0;
        last_acc = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_a      = '0;
        i_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(o_ready), 1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_diff", int'(o_diff), 0);
        check("rst_borrow", int'(o_borrow), 0);
        rst_n = 1'b1;

        // Basic and boundary vectors
        send(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        send(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        send(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        send(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        send(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        drain();

        // Backpressure: result must stay put for 5 DONE cycles
        i_ready = 1'b0;
        send(8'h81, 8'h7F, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        for (int unsigned k = 0; k < 50 && !o_valid; k++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_seen", int'(o_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        i_ready = 1'b1;
        drain();

        // Busy-ignore: i_valid stays high with a second pair during CALC/DONE
        send(8'hC3, 8'h3C, 8'h87, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22, acc);
        send(8'h11, 8'h22, 8'hEF, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        drain();

        // Reset in the 4th CALC cycle discards the operation
        send(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", int'(o_ready), 1);
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_diff", int'(o_diff), 0);
        check("mid_rst_borrow", int'(o_borrow), 0);
        rst_n  = 1'b1;
        vcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_valid) vcount++;
        end
        check("mid_rst_no_valid", vcount, 0);

        // Back-to-back random operations against (a-b) mod 256 and a<b
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, ra - rb, (ra < rb), 1'b1, 1'b0, 8'h00, 8'h00, acc);
            if (i > 0) check("throughput", acc - last_acc, int'(W) + 2);
            last_acc = acc;
        end
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pes_serial_subtractor.md
PES_SERIAL_SUBTRACTOR -- requirements
Module: pes_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_valid  input  1  operand pair present on i_a/i_b.
REQ-005 SHALL have port o_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port i_a  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port i_b  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port o_valid  output  1  result present on o_diff/o_borrow.
REQ-009 SHALL have port i_ready  input  1  downstream accepts result.
REQ-010 SHALL have port o_diff  output  WIDTH  (i_a - i_b) mod 2^WIDTH.
REQ-011 SHALL have port o_borrow  output  1  final borrow out; 1 exactly when i_a < i_b.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive o_ready=1 only in IDLE and o_valid=1 only in DONE.
REQ-014 SHALL accept operands on a cycle with i_valid=1 and o_ready=1: capture i_a/i_b into shift registers, clear borrow register and bit counter, go to CALC.
REQ-015 SHALL, in IDLE with i_valid=0, remain in IDLE with registers unchanged.
REQ-016 SHALL, in each CALC cycle, process one bit pair LSB-first: diff = a^b^borrow, borrow_next = (~a&b) | (~(a^b)&borrow); shift diff into the result register MSB-side; shift both operand registers right by one; increment counter.
REQ-017 SHALL leave CALC after exactly WIDTH cycles (counter reaches WIDTH-1 and is processed) and enter DONE with o_diff = full result and o_borrow = final borrow.
REQ-018 SHALL assert o_valid exactly WIDTH+1 cycles after the accept edge; accept-to-accept throughput with i_ready=1 is WIDTH+2 cycles.
REQ-019 SHALL hold o_diff and o_borrow stable in DONE until the cycle with i_ready=1, then return to IDLE; o_ready rises on the following cycle.
REQ-020 SHALL ignore i_valid, i_a, i_b while in CALC or DONE; no operand is queued.
REQ-021 SHALL keep o_diff/o_borrow at their last computed values in IDLE and CALC (not qualified; meaningful only with o_valid).
REQ-022 SHALL produce wrap-around results: equal operands give o_diff=0, o_borrow=0; i_a=0, i_b=1 gives all-ones, o_borrow=1.
REQ-023 SHALL size the bit counter to clog2(WIDTH) bits with no wrap before the terminal count.

Reset
REQ-024 SHALL, on an edge with i_rst_n=0, force state IDLE, o_ready=1 on the following cycle, o_valid=0, o_diff=0, o_borrow=0, counter=0, operand registers=0.
REQ-025 SHALL let reset override every other event, including mid-CALC and a DONE-state handshake on the same edge; the in-flight operation is discarded with no o_valid.
REQ-026 SHALL NOT use asynchronous reset on any flop.

Structure
REQ-027 SHALL place the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH constant in a shared package pes_arith_pkg.
REQ-028 SHALL instantiate one combinational sub-module pes_full_subtractor (inputs a, b, bin; outputs diff, bout) for the per-bit step; no other hierarchy.
REQ-029 SHALL contain no latches and no combinational path from i_valid to o_valid or from i_ready to o_ready.

Verification (WIDTH=8)
REQ-030 SHALL check basic: accept 0x5A, 0x3C with i_ready=1 -> o_valid 9 cycles later, o_diff=0x1E, o_borrow=0, o_ready back one cycle after handshake.
REQ-031 SHALL check underflow/equal: 0x00-0x01 -> 0xFF, borrow 1; 0xA5-0xA5 -> 0x00, borrow 0; 0xFF-0x00 -> 0xFF, borrow 0.
REQ-032 SHALL check backpressure: i_ready=0 for 5 cycles in DONE -> o_valid, o_diff, o_borrow held constant; single handshake on release.
REQ-033 SHALL check busy-ignore: i_valid=1 with new operands throughout CALC/DONE -> first result unaffected, second pair accepted only in IDLE.
REQ-034 SHALL check reset mid-operation: assert i_rst_n=0 on 4th CALC cycle -> next cycle IDLE, o_valid never asserted, outputs 0, o_ready=1.
REQ-035 SHALL check randomized back-to-back pairs against reference model (a-b) mod 256 and a<b for at least 1000 operations.
